// File: rtl/series_accumulator_if.sv
// Operand stream (source -> reducer) and result stream (reducer -> consumer) of series_accumulator.
// The slave modport is the reducer side; master is the source/consumer side.
interface series_accumulator_if #(
  parameter int LANES     = 8,
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_sum;
  logic [15:0]            out_count;
  logic                   out_overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/series_accumulator.sv
// Streaming series reducer: an input register and a registered adder tree sum each beat,
// then beat sums accumulate until in_last. Define SERIES_ACC_SAT_EN to saturate instead of wrap.
module series_accumulator #(
  parameter int LANES     = 8,
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  series_accumulator_if.slave  bus
);
  localparam int LEVELS = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int NODES  = 2 * LANES - 1;
  localparam int MSB    = ACC_WIDTH - 1;

  function automatic logic [ACC_WIDTH-1:0] ext_lane(input logic [WIDTH-1:0] x);
    logic [ACC_WIDTH-1:0] r;
    r = ((SIGNED != 0) && x[WIDTH-1]) ? {ACC_WIDTH{1'b1}} : {ACC_WIDTH{1'b0}};
    r[WIDTH-1:0] = x;
    return r;
  endfunction

  // Heap-ordered tree: node j sums children 2j+1 and 2j+2; leaves (the input
  // register) occupy LANES-1..NODES-1, the root is node 0.
  logic [ACC_WIDTH-1:0] node_d [NODES];
  logic [ACC_WIDTH-1:0] node_q [NODES];
  logic [LEVELS:0]      vld_d, vld_q;
  logic [LEVELS:0]      lst_d, lst_q;

  logic                 adv_s;
  logic [ACC_WIDTH-1:0] base_s;
  logic [ACC_WIDTH-1:0] root_s;
  logic [ACC_WIDTH:0]   sum_ext_s;
  logic [ACC_WIDTH-1:0] raw_s;
  logic                 ovf_s;
  logic [ACC_WIDTH-1:0] new_acc_s;
  logic                 new_ovf_s;
  logic [15:0]          new_cnt_s;

  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic [15:0]          cnt_d, cnt_q;
  logic                 ovf_d, ovf_q;
  logic                 first_d, first_q;
  logic                 out_valid_d, out_valid_q;
  logic [ACC_WIDTH-1:0] out_sum_d, out_sum_q;
  logic [15:0]          out_count_d, out_count_q;
  logic                 out_overflow_d, out_overflow_q;

  assign adv_s            = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready     = adv_s & reset_n;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_overflow_q;

  // Next value of every tree node and of the per-stage valid/last tags
  always_comb begin
    for (int j = 0; j < LANES - 1; j++) begin
      node_d[j] = node_q[2*j+1] + node_q[2*j+2];
    end
    for (int i = 0; i < LANES; i++) begin
      node_d[LANES-1+i] = ext_lane(bus.in_data[i*WIDTH +: WIDTH]);
    end
    vld_d[0] = bus.in_valid;
    lst_d[0] = bus.in_valid & bus.in_last;
    for (int k = 1; k <= LEVELS; k++) begin
      vld_d[k] = vld_q[k-1];
      lst_d[k] = lst_q[k-1];
    end
  end

  // Tree pipeline registers, frozen while the result is back-pressured
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NODES; j++) begin
        node_q[j] <= {ACC_WIDTH{1'b0}};
      end
      vld_q <= '0;
      lst_q <= '0;
    end else if (adv_s) begin
      node_q <= node_d;
      vld_q  <= vld_d;
      lst_q  <= lst_d;
    end else begin
      vld_q  <= vld_q;
    end
  end

  // Accumulate the root sum, detect overflow and build the next result
  always_comb begin
    root_s    = node_q[0];
    base_s    = first_q ? {ACC_WIDTH{1'b0}} : acc_q;
    sum_ext_s = {1'b0, base_s} + {1'b0, root_s};
    raw_s     = sum_ext_s[ACC_WIDTH-1:0];
    if (SIGNED != 0) begin
      ovf_s = (base_s[MSB] == root_s[MSB]) && (raw_s[MSB] != base_s[MSB]);
    end else begin
      ovf_s = sum_ext_s[ACC_WIDTH];
    end
`ifdef SERIES_ACC_SAT_EN
    if (ovf_s) begin
      if (SIGNED != 0) begin
        // Both operands share a sign on overflow, so the root's sign gives the direction.
        new_acc_s = root_s[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        new_acc_s = {ACC_WIDTH{1'b1}};
      end
    end else begin
      new_acc_s = raw_s;
    end
`else
    new_acc_s = raw_s;
`endif
    new_ovf_s = (first_q ? 1'b0 : ovf_q) | ovf_s;
    if (first_q) begin
      new_cnt_s = 16'd1;
    end else if (cnt_q == 16'hFFFF) begin
      new_cnt_s = 16'hFFFF;
    end else begin
      new_cnt_s = cnt_q + 16'd1;
    end

    acc_d          = acc_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    first_d        = first_q;
    out_sum_d      = out_sum_q;
    out_count_d    = out_count_q;
    out_overflow_d = out_overflow_q;
    out_valid_d    = out_valid_q && !bus.out_ready;

    if (adv_s && vld_q[LEVELS]) begin
      if (lst_q[LEVELS]) begin
        out_sum_d      = new_acc_s;
        out_count_d    = new_cnt_s;
        out_overflow_d = new_ovf_s;
        out_valid_d    = 1'b1;
        acc_d          = {ACC_WIDTH{1'b0}};
        cnt_d          = 16'd0;
        ovf_d          = 1'b0;
        first_d        = 1'b1;
      end else begin
        acc_d          = new_acc_s;
        cnt_d          = new_cnt_s;
        ovf_d          = new_ovf_s;
        first_d        = 1'b0;
      end
    end else begin
      first_d = first_q;
    end
  end

  // Accumulator and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q          <= {ACC_WIDTH{1'b0}};
      cnt_q          <= 16'd0;
      ovf_q          <= 1'b0;
      first_q        <= 1'b1;
      out_valid_q    <= 1'b0;
      out_sum_q      <= {ACC_WIDTH{1'b0}};
      out_count_q    <= 16'd0;
      out_overflow_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      first_q        <= first_d;
      out_valid_q    <= out_valid_d;
      out_sum_q      <= out_sum_d;
      out_count_q    <= out_count_d;
      out_overflow_q <= out_overflow_d;
    end
  end
endmodule

// File: tb/tb_series_accumulator.sv
// Directed bench for series_accumulator: three 8-lane builds share one operand stream,
// a 1-lane 8-bit build exercises signed overflow and minimum latency.
module tb_series_accumulator;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  series_accumulator_if #(.LANES(8), .WIDTH(32), .ACC_WIDTH(48)) bus0 ();
  series_accumulator_if #(.LANES(8), .WIDTH(32), .ACC_WIDTH(48)) bus1 ();
  series_accumulator_if #(.LANES(8), .WIDTH(32), .ACC_WIDTH(36)) bus2 ();
  series_accumulator_if #(.LANES(1), .WIDTH(8),  .ACC_WIDTH(8))  bus3 ();

  series_accumulator #(.LANES(8), .WIDTH(32), .ACC_WIDTH(48), .SIGNED(1)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
  series_accumulator #(.LANES(8), .WIDTH(32), .ACC_WIDTH(48), .SIGNED(0)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));
  series_accumulator #(.LANES(8), .WIDTH(32), .ACC_WIDTH(36), .SIGNED(0)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2));
  series_accumulator #(.LANES(1), .WIDTH(8), .ACC_WIDTH(8), .SIGNED(1)) u3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3));

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_data   = bus0.in_data;
  assign bus1.in_last   = bus0.in_last;
  assign bus1.out_ready = bus0.out_ready;
  assign bus2.in_valid  = bus0.in_valid;
  assign bus2.in_data   = bus0.in_data;
  assign bus2.in_last   = bus0.in_last;
  assign bus2.out_ready = bus0.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] fill8(input logic [31:0] v);
    return {8{v}};
  endfunction

  // Offer one beat on bus0 (from a negedge); returns at the negedge after acceptance.
  task automatic beat0(input logic [255:0] d, input logic last);
    int n;
    n = 0;
    bus0.in_valid = 1'b1;
    bus0.in_data  = d;
    bus0.in_last  = last;
    while (!bus0.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept0", {63'd0, bus0.in_ready}, 64'd1);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    bus0.in_last  = 1'b0;
  endtask

  task automatic beat3(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    bus3.in_valid = 1'b1;
    bus3.in_data  = d;
    bus3.in_last  = last;
    while (!bus3.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept3", {63'd0, bus3.in_ready}, 64'd1);
    @(negedge clk);
    bus3.in_valid = 1'b0;
    bus3.in_last  = 1'b0;
  endtask

  task automatic wait_out0();
    int n;
    n = 0;
    while (!bus0.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out0", {63'd0, bus0.out_valid}, 64'd1);
  endtask

  task automatic wait_out3();
    int n;
    n = 0;
    while (!bus3.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out3", {63'd0, bus3.out_valid}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] d;
    n_cmp = 0;
    n_err = 0;
    reset_n        = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.in_data   = '0;
    bus0.in_last   = 1'b0;
    bus0.out_ready = 1'b1;
    bus3.in_valid  = 1'b0;
    bus3.in_data   = '0;
    bus3.in_last   = 1'b0;
    bus3.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready",  bus0.in_ready,     0);
    chk("rst_out_valid", bus0.out_valid,    0);
    chk("rst_out_sum",   bus0.out_sum,      0);
    chk("rst_out_count", bus0.out_count,    0);
    chk("rst_out_ovf",   bus0.out_overflow, 0);
    chk("rst_in_ready3", bus3.in_ready,     0);
    reset_n = 1'b1;
    #1;
    chk("run_in_ready",  bus0.in_ready,     1);
    @(negedge clk);

    // Single beat, lanes 1..8, latency 4
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(i + 1);
    beat0(d, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("lat_low", bus0.out_valid, 0);
      @(negedge clk);
    end
    chk("lat_high",     bus0.out_valid,    1);
    chk("single_sum",   bus0.out_sum,      36);
    chk("single_count", bus0.out_count,    1);
    chk("single_ovf",   bus0.out_overflow, 0);
    @(negedge clk);
    chk("single_pulse", bus0.out_valid,    0);

    // Multi-beat with bubbles
    beat0(fill8(32'd5), 1'b0);
    repeat (2) @(negedge clk);
    beat0(fill8(32'd5), 1'b0);
    @(negedge clk);
    beat0(fill8(32'd5), 1'b1);
    wait_out0();
    chk("multi_sum",   bus0.out_sum,      120);
    chk("multi_count", bus0.out_count,    3);
    chk("multi_ovf",   bus0.out_overflow, 0);
    @(negedge clk);

    // Back-to-back one-beat series
    beat0(fill8(32'd7), 1'b1);
    beat0(fill8(32'd1), 1'b1);
    wait_out0();
    chk("b2b_sum1",  bus0.out_sum,   56);
    @(negedge clk);
    chk("b2b_valid", bus0.out_valid, 1);
    chk("b2b_sum2",  bus0.out_sum,   8);
    @(negedge clk);

    // Back-pressure: two series held behind an unconsumed result
    bus0.out_ready = 1'b0;
    beat0(fill8(32'd2), 1'b1);
    beat0(fill8(32'd3), 1'b0);
    beat0(fill8(32'd3), 1'b1);
    wait_out0();
    for (int i = 0; i < 10; i++) begin
      chk("bp_in_ready", bus0.in_ready,  0);
      chk("bp_valid",    bus0.out_valid, 1);
      chk("bp_sum1",     bus0.out_sum,   16);
      chk("bp_count1",   bus0.out_count, 1);
      @(negedge clk);
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_gap",    bus0.out_valid, 0);
    @(negedge clk);
    chk("bp_valid2", bus0.out_valid, 1);
    chk("bp_sum2",   bus0.out_sum,   48);
    chk("bp_count2", bus0.out_count, 2);
    @(negedge clk);

    // Sign versus zero extension of all-ones lanes
    beat0(fill8(32'hFFFF_FFFF), 1'b1);
    wait_out0();
    chk("sx_signed",   bus0.out_sum,      48'hFFFF_FFFF_FFF8);
    chk("sx_sovf",     bus0.out_overflow, 0);
    chk("sx_unsigned", bus1.out_sum,      48'h0007_FFFF_FFF8);
    chk("sx_u36",      bus2.out_sum,      36'h7_FFFF_FFF8);
    chk("sx_u36_ovf",  bus2.out_overflow, 0);
    @(negedge clk);

    // Unsigned overflow of the 36-bit accumulator
    beat0(fill8(32'hFFFF_FFFF), 1'b0);
    beat0(fill8(32'hFFFF_FFFF), 1'b0);
    beat0(fill8(32'hFFFF_FFFF), 1'b1);
    wait_out0();
`ifdef SERIES_ACC_SAT_EN
    chk("ovf36_sum",   bus2.out_sum,      36'hF_FFFF_FFFF);
`else
    chk("ovf36_sum",   bus2.out_sum,      36'h7_FFFF_FFE8);
`endif
    chk("ovf36_flag",  bus2.out_overflow, 1);
    chk("ovf36_count", bus2.out_count,    3);
    chk("ovf48_sum",   bus1.out_sum,      48'h0017_FFFF_FFE8);
    chk("ovf48_flag",  bus1.out_overflow, 0);
    chk("ovfs_sum",    bus0.out_sum,      48'hFFFF_FFFF_FFE8);
    chk("ovfs_flag",   bus0.out_overflow, 0);
    @(negedge clk);

    // Reset in the middle of a series
    beat0(fill8(32'd4), 1'b0);
    beat0(fill8(32'd4), 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus0.in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("abort_quiet", bus0.out_valid, 0);
      @(negedge clk);
    end
    beat0(fill8(32'd1), 1'b1);
    wait_out0();
    chk("post_rst_sum",   bus0.out_sum,      8);
    chk("post_rst_count", bus0.out_count,    1);
    chk("post_rst_ovf",   bus0.out_overflow, 0);
    chk("post_rst_u36",   bus2.out_sum,      8);
    chk("post_rst_u36f",  bus2.out_overflow, 0);
    @(negedge clk);

    // One lane: one-cycle latency and signed overflow in both directions
    beat3(8'h05, 1'b1);
    chk("l1_lat_low",  bus3.out_valid, 0);
    @(negedge clk);
    chk("l1_lat_high", bus3.out_valid, 1);
    chk("l1_sum",      bus3.out_sum,   8'h05);
    @(negedge clk);

    beat3(8'h70, 1'b0);
    beat3(8'h20, 1'b1);
    wait_out3();
`ifdef SERIES_ACC_SAT_EN
    chk("pos_ovf_sum", bus3.out_sum, 8'h7F);
`else
    chk("pos_ovf_sum", bus3.out_sum, 8'h90);
`endif
    chk("pos_ovf_flag",  bus3.out_overflow, 1);
    chk("pos_ovf_count", bus3.out_count,    2);
    @(negedge clk);

    beat3(8'h80, 1'b0);
    beat3(8'hFF, 1'b1);
    wait_out3();
`ifdef SERIES_ACC_SAT_EN
    chk("neg_ovf_sum", bus3.out_sum, 8'h80);
`else
    chk("neg_ovf_sum", bus3.out_sum, 8'h7F);
`endif
    chk("neg_ovf_flag", bus3.out_overflow, 1);
    @(negedge clk);

    beat3(8'h70, 1'b0);
    beat3(8'h20, 1'b0);
    beat3(8'hF0, 1'b1);
    wait_out3();
`ifdef SERIES_ACC_SAT_EN
    chk("recover_sum", bus3.out_sum, 8'h6F);
`else
    chk("recover_sum", bus3.out_sum, 8'h80);
`endif
    chk("recover_flag",  bus3.out_overflow, 1);
    chk("recover_count", bus3.out_count,    3);
    @(negedge clk);

    beat3(8'h01, 1'b1);
    wait_out3();
    chk("flag_clear", bus3.out_overflow, 0);
    chk("flag_sum",   bus3.out_sum,      8'h01);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/series_accumulator.md
# series_accumulator

Streaming, parametrised integer series reducer. Accepts LANES operands per beat over a valid/ready handshake. Each beat is reduced through a registered adder tree, and the beat sums are accumulated until a beat marked last. It then presents one result per series: the sum, the beat count and an overflow flag. It sits between the operand stream source and result consumer in the reduction datapath, replacing the fixed-size, single-shot reducer.

## Interface

**Parameters**
- LANES, 8: operands per beat; power of 2, 1..64.
- WIDTH, 32: operand width.
- ACC_WIDTH, 48: accumulator/result width; must be ≥ WIDTH+log2(LANES).
- SIGNED, 1: 1 = operands are two's complement, sign-extended; 0 = unsigned, zero-extended.

**Ports**
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid && in_ready at a clk edge.
- in_data  in  LANES*WIDTH  operands; lane i = in_data[i*WIDTH +: WIDTH].
- in_last  in  1  beat is the final beat of the series.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_WIDTH  series sum.
- out_count  out  16  beats in the series; saturates at 16'hFFFF.
- out_overflow  out  1  accumulator overflowed at least once during the series.

## Operation

- Pipeline
  - log2(LANES) tree stages, then one accumulate/output stage.
  - Each tree stage registers its partial sums plus valid and last.
  - Lanes are extended to ACC_WIDTH before the tree, so the tree cannot overflow.
- Stall
  - adv = !(out_valid && !out_ready).
  - All pipeline registers load only when adv = 1.
  - in_ready = adv while reset_n high, 0 while reset_n low.
- Accumulate stage, on a valid tree result with adv:
  - acc_next = (first ? 0 : acc) + tree_sum, computed at ACC_WIDTH.
  - Overflow is detected per SIGNED:
    - signed: operand signs equal and result sign differs.
    - unsigned: carry out.
  - The sticky overflow flag, like acc, is reset by first.
  - The count increments, saturating at 16'hFFFF.
- Last beat
  - Loads out_sum = acc_next, out_count and out_overflow (including this beat's overflow), and sets out_valid.
  - Clears acc, count and the flag, and sets first.
  - Otherwise first is cleared.
- Output handshake
  - out_valid falls on out_valid && out_ready unless a new last beat loads at the same edge, in which case out_valid stays high with the new values.
  - out_sum, out_count and out_overflow are stable while out_valid && !out_ready.
- A beat with in_last = 1 only is a one-beat series, which is legal.
- in_data and in_last are ignored when in_valid = 0; bubbles are allowed anywhere within a series.

## Timing

- Reset (asynchronous, reset_n low) clears:
  - all stage valids, acc, count, flags, out_valid, out_sum, out_count and out_overflow to 0;
  - first to 1.
- Latency: the last beat accepted at edge t gives out_valid high after edge t+log2(LANES)+1 (LANES=8: 4 cycles; LANES=1: 1 cycle), provided no stall.
- Throughput: one beat per cycle. Back-to-back series have no gap when out_ready = 1.
- Stall: while out_valid && !out_ready, in_ready = 0 and no register changes. It resumes on the cycle after out_ready rises, with no data lost or duplicated.
- Reset mid-series discards the partial sum and all in-flight beats. The first beat after reset starts a new series.

## Configuration

- SERIES_ACC_SAT_EN defined:
  - On overflow the accumulator saturates instead of wrapping:
    - signed: to the max/min of ACC_WIDTH in the overflow direction;
    - unsigned: to all-ones.
  - It stays saturated for the rest of the series, unless later beats move it back in range by normal addition from the saturated value.
  - out_overflow is still reported.
- Undefined: the accumulator wraps modulo 2^ACC_WIDTH; out_overflow is still reported.

## Test plan

- **Single beat:** LANES=8, SIGNED=1, lanes 1..8 with in_last = 1 → out_sum = 36, out_count = 1, out_overflow = 0, out_valid exactly 4 cycles after acceptance.
- **Multi-beat with bubbles:** 3 beats, all lanes = 5, with in_valid gaps, last on beat 3 → out_sum = 120, out_count = 3.
- **Back-pressure:** hold out_ready = 0 for 10 cycles while 2 series stream → in_ready = 0 during the hold, result 1 stable. Release → both results arrive in order, none lost.
- **Signed extension:** all lanes = 32'hFFFFFFFF (−1), 1 beat → out_sum = −8 sign-extended to 48 bits. With SIGNED=0 → out_sum = 8 × 4294967295 = 48'h0007_FFFF_FFF8.
- **Overflow:** ACC_WIDTH=36, SIGNED=0, repeat all-ones beats until the sum passes 2^36 → out_overflow = 1. The sum wraps without SERIES_ACC_SAT_EN and equals 36'hF_FFFF_FFFF with it.
- **Reset mid-series:** 2 beats accepted, reset_n pulsed low for 1 cycle, then one beat of lanes = 1 with last → out_sum = 8, out_count = 1. No output is produced for the aborted series.
